// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a state machine with a bounded memory-wait counter and sticky trap flags.
// Each state decodes its own datapath controls. Illegal opcodes and memory timeouts lock the unit in TRAP until reset.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ENABLE_JAL  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       wait_state;
  logic       wait_expired;
  logic       set_illegal;
  logic       set_timeout;

  // Memory handshake: mem_read/mem_write stay asserted for the whole access.
  // The access completes in the cycle mem_ready=1. After MEM_TIMEOUT cycles
  // without mem_ready, the access is abandoned and the unit traps.
  assign wait_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wait_expired = wait_state && !mem_ready && (wait_cnt == WAIT_LAST);
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt    <= 8'd0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal     <= illegal | set_illegal;
      mem_timeout <= mem_timeout | set_timeout;
      if (state_d != state_q)
        wait_cnt <= 8'd0;
      else if (wait_state && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    regdst      = 2'd0;
    memtoreg    = 2'd0;
    alusrca     = 1'b0;
    alusrcb     = 2'd0;
    aluop       = 2'd0;
    pcsrc       = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = (ENABLE_JAL != 0) ? S_JUMP : S_TRAP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
        set_illegal = (state_d == S_TRAP);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memtoreg  = 2'd1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'd2;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        regdst    = 2'd1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'd1;
        pcsrc    = 2'd1;
        pc_write = zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc    = 2'd2;
        pc_write = 1'b1;
        // PC already holds PC+4 here, so jal links it straight into $31.
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          regdst    = 2'd2;
          memtoreg  = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pcsrc    = 2'd3;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: default, short-timeout and no-jal instances share one input stream.
// It checks state traces, control decodes, wait/timeout handling, illegal traps and reset behaviour.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsrc;
  logic       alusrca, illegal, mem_timeout;
  logic [3:0] state;

  logic       t_pc_write, t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_write;
  logic [1:0] t_regdst, t_memtoreg, t_alusrcb, t_aluop, t_pcsrc;
  logic       t_alusrca, t_illegal, t_mem_timeout;
  logic [3:0] t_state;

  logic       n_pc_write, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_write;
  logic [1:0] n_regdst, n_memtoreg, n_alusrcb, n_aluop, n_pcsrc;
  logic       n_alusrca, n_illegal, n_mem_timeout;
  logic [3:0] n_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  mips_multicycle_control #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(t_pc_write), .iord(t_iord), .mem_read(t_mem_read), .mem_write(t_mem_write), .ir_write(t_ir_write),
    .reg_write(t_reg_write), .regdst(t_regdst), .memtoreg(t_memtoreg), .alusrca(t_alusrca), .alusrcb(t_alusrcb),
    .aluop(t_aluop), .pcsrc(t_pcsrc), .state(t_state), .illegal(t_illegal), .mem_timeout(t_mem_timeout)
  );

  mips_multicycle_control #(.ENABLE_JAL(0)) dut_n (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .iord(n_iord), .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_write(n_reg_write), .regdst(n_regdst), .memtoreg(n_memtoreg), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .aluop(n_aluop), .pcsrc(n_pcsrc), .state(n_state), .illegal(n_illegal), .mem_timeout(n_mem_timeout)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked 2ns later.
  task automatic at(input string tag, input logic [3:0] exp_state);
    #2;
    check(tag, {4'd0, state}, {4'd0, exp_state});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    tick();
    #2;
    check("reset_strobes", {3'd0, pc_write, mem_read, mem_write, ir_write, reg_write}, 8'h00);
    check("reset_t_strobes", {3'd0, t_pc_write, t_mem_read, t_mem_write, t_ir_write, t_reg_write}, 8'h00);
    tick();
    reset = 1'b0;
    check("reset_state", {4'd0, state}, 8'h00);
    check("reset_flags", {6'd0, illegal, mem_timeout}, 8'h00);

    // lw
    opcode = 6'b100011;
    at("lw_s0", 4'd0);
    check("lw_fetch_ctl", {mem_read, iord, ir_write, pc_write, alusrca, alusrcb, 1'b0}, 8'b1011_0010);
    tick();
    at("lw_s1", 4'd1);
    check("lw_dec_alusrcb", {6'd0, alusrcb}, 8'd3);
    tick();
    at("lw_s2", 4'd2);
    check("lw_adr_ctl", {3'd0, alusrca, alusrcb, aluop}, {3'd0, 1'b1, 2'd2, 2'd0});
    tick();
    at("lw_s3", 4'd3); tick();
    at("lw_s4", 4'd4);
    check("lw_wb_ctl", {3'd0, reg_write, regdst, memtoreg}, {3'd0, 1'b1, 2'd0, 2'd1});
    tick();
    // sw
    opcode = 6'b101011;
    at("sw_s0", 4'd0); tick();
    at("sw_s1", 4'd1); tick();
    at("sw_s2", 4'd2); tick();
    at("sw_s5", 4'd5);
    check("sw_wr_ctl", {6'd0, mem_write, iord}, 8'd3);
    tick();
    // add
    opcode = 6'b000000; funct = 6'b100000;
    at("add_s0", 4'd0); tick();
    at("add_s1", 4'd1); tick();
    at("add_s6", 4'd6);
    check("add_exec_ctl", {3'd0, alusrca, alusrcb, aluop}, {3'd0, 1'b1, 2'd0, 2'd2});
    tick();
    at("add_s7", 4'd7);
    check("add_wb_ctl", {3'd0, reg_write, regdst, memtoreg}, {3'd0, 1'b1, 2'd1, 2'd0});
    tick();
    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    at("beq_s0", 4'd0); tick();
    at("beq_s1", 4'd1); tick();
    at("beq_s8", 4'd8);
    check("beq_taken_ctl", {1'b0, pc_write, pcsrc, aluop, 2'd0}, {1'b0, 1'b1, 2'd1, 2'd1, 2'd0});
    tick();
    // j
    opcode = 6'b000010; zero = 1'b0;
    at("j_s0", 4'd0); tick();
    at("j_s1", 4'd1); tick();
    at("j_s9", 4'd9);
    check("j_ctl", {3'd0, pc_write, pcsrc, 1'b0, reg_write}, {3'd0, 1'b1, 2'd2, 1'b0, 1'b0});
    tick();
    // beq not taken
    opcode = 6'b000100; zero = 1'b0;
    at("beqn_s0", 4'd0); tick();
    at("beqn_s1", 4'd1); tick();
    at("beqn_s8", 4'd8);
    check("beqn_pc_write", {7'd0, pc_write}, 8'd0);
    tick();
    // jr
    opcode = 6'b000000; funct = 6'b001000;
    at("jr_s0", 4'd0); tick();
    at("jr_s1", 4'd1); tick();
    at("jr_s12", 4'd12);
    check("jr_ctl", {5'd0, pc_write, pcsrc}, {5'd0, 1'b1, 2'd3});
    tick();
    // addi
    opcode = 6'b001000; funct = 6'b0;
    at("addi_s0", 4'd0); tick();
    at("addi_s1", 4'd1); tick();
    at("addi_s10", 4'd10);
    check("addi_ex_ctl", {5'd0, alusrca, alusrcb}, {5'd0, 1'b1, 2'd2});
    tick();
    at("addi_s11", 4'd11);
    check("addi_wb_ctl", {3'd0, reg_write, regdst, memtoreg}, {3'd0, 1'b1, 2'd0, 2'd0});
    tick();

    // lw with three wait cycles in MEMRD
    opcode = 6'b100011;
    at("lww_s0", 4'd0); tick();
    at("lww_s1", 4'd1); tick();
    at("lww_s2", 4'd2); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at("lww_wait", 4'd3);
      check("lww_wait_rd", {6'd0, mem_read, iord}, 8'd3);
      tick();
    end
    mem_ready = 1'b1;
    at("lww_s3_done", 4'd3); tick();
    at("lww_s4", 4'd4);
    check("lww_wb_ctl", {4'd0, reg_write, 1'b0, memtoreg}, {4'd0, 1'b1, 1'b0, 2'd1});
    tick();
    at("lww_back", 4'd0);

    // illegal opcode
    do_reset();
    opcode = 6'b111111;
    at("ill_s0", 4'd0); tick();
    at("ill_s1", 4'd1); tick();
    at("ill_trap", 4'd15);
    check("ill_flag", {6'd0, illegal, mem_timeout}, 8'b10);
    check("ill_strobes", {3'd0, pc_write, mem_read, mem_write, ir_write, reg_write}, 8'h00);
    tick();
    at("ill_stuck", 4'd15);

    // jal: legal on default instance, illegal when disabled
    do_reset();
    opcode = 6'b000011;
    at("jal_s0", 4'd0); tick();
    at("jal_s1", 4'd1);
    check("jaln_s1", {4'd0, n_state}, 8'd1);
    tick();
    at("jal_s9", 4'd9);
    check("jal_ctl", {1'b0, reg_write, regdst, memtoreg, pc_write, 1'b0}, {1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0});
    check("jaln_trap", {4'd0, n_state}, 8'd15);
    check("jaln_illegal", {7'd0, n_illegal}, 8'd1);
    tick();
    check("jal_back", {4'd0, state}, 8'd0);

    // fetch timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("to_wait", {4'd0, t_state}, 8'd0);
      tick();
    end
    #2;
    check("to_trap", {4'd0, t_state}, 8'd15);
    check("to_flags", {6'd0, t_illegal, t_mem_timeout}, 8'b01);
    check("to_strobes", {3'd0, t_pc_write, t_mem_read, t_mem_write, t_ir_write, t_reg_write}, 8'h00);
    check("to_dflt_still_fetch", {4'd0, state}, 8'd0);
    mem_ready = 1'b1;
    tick();
    #2;
    check("to_stuck", {4'd0, t_state}, 8'd15);
    check("to_stuck_strobes", {3'd0, t_pc_write, t_mem_read, t_mem_write, t_ir_write, t_reg_write}, 8'h00);
    tick();
    do_reset();
    #2;
    check("to_reset_state", {4'd0, t_state}, 8'd0);
    check("to_reset_flags", {6'd0, t_illegal, t_mem_timeout}, 8'b00);
    tick();

    // reset during MEMWR wait
    do_reset();
    opcode = 6'b101011; mem_ready = 1'b1;
    at("rw_s0", 4'd0); tick();
    at("rw_s1", 4'd1); tick();
    at("rw_s2", 4'd2); tick();
    mem_ready = 1'b0;
    at("rw_s5", 4'd5); tick();
    at("rw_s5b", 4'd5);
    reset = 1'b1;
    #1;
    check("rw_mem_write_gated", {7'd0, mem_write}, 8'd0);
    tick();
    reset = 1'b0;
    at("rw_fetch", 4'd0);
    check("rw_flags", {6'd0, illegal, mem_timeout}, 8'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
